// File: rtl/shmem_core_port.sv
// shmem_core_port: per-core initiator for the 16-bank shared memory (read/write/core_val -> finish).
// Ports: clock/reset (async, active-high); req_* valid/ready core request in; resp_* valid/ready
// response out; busy; sm_* drive one request at a time to the shared memory, sm_finish completes it.
// Optional: define SHMEM_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES cycles in REQ (resp_err=1).
module shmem_core_port #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 8,
  parameter int QDEPTH         = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              sm_read,
  output logic              sm_write,
  output logic              sm_core_val,
  output logic [ADDR_W-1:0] sm_addr,
  output logic [DATA_W-1:0] sm_wdata,
  input  logic [DATA_W-1:0] sm_rdata,
  input  logic              sm_finish
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              q_write [QDEPTH];
  logic [ADDR_W-1:0] q_addr  [QDEPTH];
  logic [DATA_W-1:0] q_wdata [QDEPTH];
  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              push;
  logic              pop;
  logic              in_req;
  assign req_ready   = count != CW'(QDEPTH);
  assign push        = req_valid && req_ready;
  assign pop         = state == IDLE && count != '0;
  assign in_req      = state == REQ;
  // sm_* are decoded from flops only and forced to 0 outside REQ, so the arbiter never sees
  // a stale request once finish has been taken.
  assign sm_core_val = in_req;
  assign sm_read     = in_req && !cur_write;
  assign sm_write    = in_req && cur_write;
  assign sm_addr     = in_req ? cur_addr : '0;
  assign sm_wdata    = in_req ? cur_wdata : '0;
  assign busy        = count != '0 || state != IDLE;
  always_ff @(posedge clock) begin
    if (push) begin
      q_write[wr_ptr] <= req_write;
      q_addr[wr_ptr]  <= req_addr;
      q_wdata[wr_ptr] <= req_wdata;
    end
  end
`ifdef SHMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  // finish takes priority over an expiring counter in the same cycle
  assign tmo_hit = in_req && !sm_finish && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt  <= '0;
      resp_err <= 1'b0;
    end else begin
      tmo_cnt  <= pop ? '0 : in_req ? tmo_cnt + TW'(1) : tmo_cnt;
      resp_err <= tmo_hit ? 1'b1 : (in_req && sm_finish) ? 1'b0 : resp_err;
    end
  end
`else
  logic tmo_hit;
  assign tmo_hit  = 1'b0;
  assign resp_err = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cur_write  <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_rdata <= '0;
    end else begin
      count  <= count + CW'(push) - CW'(pop);
      wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
      if (pop) begin
        cur_write <= q_write[rd_ptr];
        cur_addr  <= q_addr[rd_ptr];
        cur_wdata <= q_wdata[rd_ptr];
        state     <= REQ;
      end
      if (in_req && (sm_finish || tmo_hit)) begin
        state      <= RESP;
        resp_valid <= 1'b1;
        resp_write <= cur_write;
        resp_rdata <= (cur_write || !sm_finish) ? '0 : sm_rdata;
      end
      if (state == RESP && resp_ready) begin
        state      <= IDLE;
        resp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_shmem_core_port.sv
// tb_shmem_core_port: directed checks of the shared-memory core port.
module tb_shmem_core_port;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_write;
  logic [7:0]  resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        sm_read;
  logic        sm_write;
  logic        sm_core_val;
  logic [11:0] sm_addr;
  logic [7:0]  sm_wdata;
  logic [7:0]  sm_rdata = '0;
  logic        sm_finish = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  shmem_core_port #(.ADDR_W(12), .DATA_W(8), .QDEPTH(2), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .sm_read(sm_read), .sm_write(sm_write), .sm_core_val(sm_core_val),
    .sm_addr(sm_addr), .sm_wdata(sm_wdata), .sm_rdata(sm_rdata), .sm_finish(sm_finish)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic w, input logic [11:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    tick;
    req_valid = 1'b0;
  endtask
  task automatic finish(input logic [7:0] d);
    sm_finish = 1'b1;
    sm_rdata  = d;
    tick;
    sm_finish = 1'b0;
    sm_rdata  = '0;
  endtask
  task automatic accept;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_core_val", sm_core_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sm_addr", sm_addr, 0);
    reset = 1'b0;
    tick;
    // T1 load
    push(1'b0, 12'h013, 8'h00);
    chk("t1_queued_busy", busy, 1);
    chk("t1_queued_core_val", sm_core_val, 0);
    tick;
    chk("t1_core_val", sm_core_val, 1);
    chk("t1_read", sm_read, 1);
    chk("t1_write", sm_write, 0);
    chk("t1_addr", sm_addr, 12'h013);
    tick;
    tick;
    chk("t1_addr_held", sm_addr, 12'h013);
    chk("t1_read_held", sm_read, 1);
    chk("t1_no_resp_yet", resp_valid, 0);
    finish(8'hA5);
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_core_val_drop", sm_core_val, 0);
    chk("t1_read_drop", sm_read, 0);
    chk("t1_rdata", resp_rdata, 8'hA5);
    chk("t1_resp_write", resp_write, 0);
    chk("t1_err", resp_err, 0);
    accept;
    chk("t1_resp_done", resp_valid, 0);
    chk("t1_idle", busy, 0);
    // T2 store
    push(1'b1, 12'hFF0, 8'h3C);
    tick;
    chk("t2_write", sm_write, 1);
    chk("t2_read", sm_read, 0);
    chk("t2_addr", sm_addr, 12'hFF0);
    chk("t2_wdata", sm_wdata, 8'h3C);
    tick;
    chk("t2_wdata_held", sm_wdata, 8'h3C);
    finish(8'h77);
    chk("t2_resp_valid", resp_valid, 1);
    chk("t2_resp_write", resp_write, 1);
    chk("t2_rdata_zero", resp_rdata, 0);
    chk("t2_sm_wdata_zero", sm_wdata, 0);
    accept;
    // T4 stray finish in IDLE
    finish(8'hEE);
    chk("t4_idle_no_resp", resp_valid, 0);
    chk("t4_idle_no_req", sm_core_val, 0);
    chk("t4_idle_busy", busy, 0);
    // T3 backpressure: A in flight, B and C fill the FIFO
    push(1'b0, 12'h001, 8'h00);
    chk("t3_ready_after_a", req_ready, 1);
    push(1'b0, 12'h002, 8'h00);
    chk("t3_ready_after_b", req_ready, 1);
    chk("t3_a_issued", sm_addr, 12'h001);
    push(1'b1, 12'h003, 8'h11);
    chk("t3_full", req_ready, 0);
    chk("t3_a_still", sm_addr, 12'h001);
    finish(8'h81);
    chk("t3_a_rdata", resp_rdata, 8'h81);
    chk("t3_a_valid", resp_valid, 1);
    // T4 resp_ready low 5 cycles with a stray finish in RESP
    for (int i = 0; i < 5; i++) begin
      sm_finish = (i == 2);
      sm_rdata  = 8'hFF;
      tick;
      chk("t4_hold_valid", resp_valid, 1);
      chk("t4_hold_rdata", resp_rdata, 8'h81);
      chk("t4_hold_write", resp_write, 0);
      chk("t4_hold_core_val", sm_core_val, 0);
    end
    sm_finish = 1'b0;
    sm_rdata  = '0;
    accept;
    chk("t3_bubble", sm_core_val, 0);
    chk("t3_still_full", req_ready, 0);
    tick;
    chk("t3_b_issued", sm_addr, 12'h002);
    chk("t3_b_read", sm_read, 1);
    chk("t3_ready_again", req_ready, 1);
    finish(8'h82);
    chk("t3_b_rdata", resp_rdata, 8'h82);
    accept;
    chk("t3_bubble2", sm_core_val, 0);
    tick;
    chk("t3_c_write", sm_write, 1);
    chk("t3_c_addr", sm_addr, 12'h003);
    chk("t3_c_wdata", sm_wdata, 8'h11);
    finish(8'h99);
    chk("t3_c_resp_write", resp_write, 1);
    chk("t3_c_rdata", resp_rdata, 0);
    accept;
    chk("t3_drained", busy, 0);
    // T5 reset mid-REQ with a second request queued
    push(1'b0, 12'h0AB, 8'h00);
    tick;
    push(1'b1, 12'h0CD, 8'h22);
    tick;
    chk("t5_in_req", sm_core_val, 1);
    reset = 1'b1;
    #1;
    chk("t5_async_core_val", sm_core_val, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ready", req_ready, 1);
    tick;
    reset = 1'b0;
    tick;
    tick;
    chk("t5_no_resp", resp_valid, 0);
    chk("t5_no_reissue", sm_core_val, 0);
    chk("t5_empty", busy, 0);
`ifdef SHMEM_TIMEOUT_EN
    // T6 timeout after 8 REQ cycles
    push(1'b0, 12'h055, 8'h00);
    tick;
    for (int i = 0; i < 7; i++) tick;
    chk("t6_still_req", sm_core_val, 1);
    chk("t6_no_resp_yet", resp_valid, 0);
    tick;
    chk("t6_tmo_valid", resp_valid, 1);
    chk("t6_tmo_err", resp_err, 1);
    chk("t6_tmo_rdata", resp_rdata, 0);
    chk("t6_tmo_core_val", sm_core_val, 0);
    accept;
    // T6 finish on the limit cycle wins
    push(1'b0, 12'h056, 8'h00);
    tick;
    for (int i = 0; i < 7; i++) tick;
    finish(8'h5A);
    chk("t6_fin_valid", resp_valid, 1);
    chk("t6_fin_err", resp_err, 0);
    chk("t6_fin_rdata", resp_rdata, 8'h5A);
    accept;
`else
    // without the timeout option REQ waits indefinitely
    push(1'b0, 12'h055, 8'h00);
    tick;
    for (int i = 0; i < 20; i++) tick;
    chk("nt_still_req", sm_core_val, 1);
    chk("nt_no_resp", resp_valid, 0);
    chk("nt_err", resp_err, 0);
    finish(8'h5A);
    chk("nt_rdata", resp_rdata, 8'h5A);
    chk("nt_err_after", resp_err, 0);
    accept;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
